halt_watch_monitor: RTL and testbench

- Parametrised run-control monitor for processor simulation and bring-up; supersedes the bench's single-address halt counter and free-running timeout.
- Watches the core's PC-load strobe against NUM_WATCH programmable addresses, each with its own hit threshold.
- Adds a loadable timeout, a simultaneous read/write detector, and sticky halt cause reporting.
- Sits beside the core; its halt output drives the bench finish logic or a debug stall.

---
 rtl/halt_watch_monitor.sv | 179 +++++++++++++++++
 tb/tb_halt_watch_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_watch_monitor.sv
// Run-control monitor: PC watch slots with hit thresholds, loadable timeout, r/w conflict counter.
// Optional macro HALT_ON_PM_ERROR_EN makes pm_error in RUN a halt event (cause 3).
module halt_watch_monitor #(
    parameter int unsigned NUM_WATCH = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned HIT_W     = 4,
    parameter int unsigned TMO_W     = 32,
    localparam int unsigned IDX_W    = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [HIT_W-1:0]  cfg_thresh,
    input  logic              tmo_we,
    input  logic [TMO_W-1:0]  tmo_value,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_out,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              pm_error,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [IDX_W-1:0]  halt_slot,
    output logic [TMO_W-1:0]  run_cycles,
    output logic [15:0]       rw_conflicts
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    localparam logic [1:0] CauseWatch   = 2'd1;
    localparam logic [1:0] CauseTimeout = 2'd2;
    localparam logic [1:0] CausePmErr   = 2'd3;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q   [NUM_WATCH];
    logic [ADDR_W-1:0]   addr_d   [NUM_WATCH];
    logic [HIT_W-1:0]    thresh_q [NUM_WATCH];
    logic [HIT_W-1:0]    thresh_d [NUM_WATCH];
    logic [HIT_W-1:0]    hit_q    [NUM_WATCH];
    logic [HIT_W-1:0]    hit_d    [NUM_WATCH];
    logic [TMO_W-1:0]    reload_q, reload_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                halt_q, halt_d;
    logic [1:0]          cause_q, cause_d;
    logic [IDX_W-1:0]    slot_q, slot_d;
    logic [TMO_W-1:0]    run_cycles_q, run_cycles_d;
    logic [15:0]         rw_q, rw_d;

    logic                watch_fire;
    logic [IDX_W-1:0]    fire_slot;
    logic                pm_ev;
    logic                tmo_ev;

`ifdef HALT_ON_PM_ERROR_EN
    assign pm_ev = pm_error;
`else
    logic unused_pm_error;
    assign unused_pm_error = pm_error;
    assign pm_ev = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        thresh_d     = thresh_q;
        hit_d        = hit_q;
        reload_d     = reload_q;
        tmo_d        = tmo_q;
        halt_d       = halt_q;
        cause_d      = cause_q;
        slot_d       = slot_q;
        run_cycles_d = run_cycles_q;
        rw_d         = rw_q;
        watch_fire   = 1'b0;
        fire_slot    = '0;
        tmo_ev       = 1'b0;

        if (mem_read && mem_write && rw_q != 16'hFFFF) begin
            rw_d = rw_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                for (int i = 0; i < NUM_WATCH; i++) begin
                    if (cfg_we && cfg_idx == IDX_W'(i)) begin
                        addr_d[i]   = cfg_addr;
                        thresh_d[i] = cfg_thresh;
                    end
                end
                if (tmo_we) begin
                    reload_d = tmo_value;
                end
                if (start) begin
                    state_d      = StRun;
                    run_cycles_d = '0;
                    // A reload written on the start cycle is used by this run.
                    tmo_d        = tmo_we ? tmo_value : reload_q;
                    for (int i = 0; i < NUM_WATCH; i++) begin
                        hit_d[i] = '0;
                    end
                end
            end
            StRun: begin
                // Scan high to low so the lowest firing index ends up in fire_slot.
                for (int i = NUM_WATCH - 1; i >= 0; i--) begin
                    if (pc_load && pc_out == addr_q[i] && thresh_q[i] != '0) begin
                        if (hit_q[i] != '1) begin
                            hit_d[i] = hit_q[i] + HIT_W'(1);
                        end
                        if (hit_q[i] == thresh_q[i] - HIT_W'(1)) begin
                            watch_fire = 1'b1;
                            fire_slot  = IDX_W'(i);
                        end
                    end
                end
                tmo_ev = (reload_q != '0) && (tmo_q == '0);
                if (tmo_q != '0) begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
                if (watch_fire || pm_ev || tmo_ev) begin
                    state_d = StHalted;
                    halt_d  = 1'b1;
                    if (watch_fire) begin
                        cause_d = CauseWatch;
                        slot_d  = fire_slot;
                    end else if (pm_ev) begin
                        cause_d = CausePmErr;
                    end else begin
                        cause_d = CauseTimeout;
                    end
                end else if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + TMO_W'(1);
                end
            end
            StHalted: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            reload_q     <= '0;
            tmo_q        <= '0;
            halt_q       <= 1'b0;
            cause_q      <= '0;
            slot_q       <= '0;
            run_cycles_q <= '0;
            rw_q         <= '0;
            for (int i = 0; i < NUM_WATCH; i++) begin
                addr_q[i]   <= '0;
                thresh_q[i] <= '0;
                hit_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            thresh_q     <= thresh_d;
            hit_q        <= hit_d;
            reload_q     <= reload_d;
            tmo_q        <= tmo_d;
            halt_q       <= halt_d;
            cause_q      <= cause_d;
            slot_q       <= slot_d;
            run_cycles_q <= run_cycles_d;
            rw_q         <= rw_d;
        end
    end

    assign halt         = halt_q;
    assign halt_cause   = cause_q;
    assign halt_slot    = slot_q;
    assign run_cycles   = run_cycles_q;
    assign rw_conflicts = rw_q;

endmodule

// File: tb/tb_halt_watch_monitor.sv
// Directed self-checking bench for halt_watch_monitor (default parameters).
module tb_halt_watch_monitor;

    logic        clk = 1'b0;
    logic        rst, start, cfg_we, tmo_we, pc_load, mem_read, mem_write, pm_error;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr, tmo_value, pc_out;
    logic [3:0]  cfg_thresh;
    logic        halt;
    logic [1:0]  halt_cause, halt_slot;
    logic [31:0] run_cycles;
    logic [15:0] rw_conflicts;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    halt_watch_monitor dut (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh), .tmo_we(tmo_we), .tmo_value(tmo_value),
        .pc_load(pc_load), .pc_out(pc_out), .mem_read(mem_read), .mem_write(mem_write),
        .pm_error(pm_error), .halt(halt), .halt_cause(halt_cause), .halt_slot(halt_slot),
        .run_cycles(run_cycles), .rw_conflicts(rw_conflicts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; tmo_we = 1'b0; pc_load = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; pm_error = 1'b0;
        cfg_idx = '0; cfg_addr = '0; cfg_thresh = '0; tmo_value = '0; pc_out = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_slot(input logic [1:0] idx, input logic [31:0] addr, input logic [3:0] th);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = addr; cfg_thresh = th;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %0d want 0", halt); end
        tests++; if (halt_cause !== 2'd0) begin fails++; $display("FAIL reset_cause: got %0d want 0", halt_cause); end
        tests++; if (halt_slot !== 2'd0) begin fails++; $display("FAIL reset_slot: got %0d want 0", halt_slot); end
        tests++; if (run_cycles !== 32'd0) begin fails++; $display("FAIL reset_run_cycles: got %0d want 0", run_cycles); end
        tests++; if (rw_conflicts !== 16'd0) begin fails++; $display("FAIL reset_rw: got %0d want 0", rw_conflicts); end
    endtask

    task automatic test_watch_single();
        do_reset();
        cfg_slot(2'd0, 32'h0000_00b0, 4'd3);
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_00b0;
        tick(); tick();
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL watch_early: got %0d want 0", halt); end
        tick();
        pc_load = 1'b0;
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL watch_halt: got %0d want 1", halt); end
        tests++; if (halt_cause !== 2'd1) begin fails++; $display("FAIL watch_cause: got %0d want 1", halt_cause); end
        tests++; if (halt_slot !== 2'd0) begin fails++; $display("FAIL watch_slot: got %0d want 0", halt_slot); end
        tests++; if (run_cycles !== 32'd2) begin fails++; $display("FAIL watch_run_cycles: got %0d want 2", run_cycles); end
        tick(); tick(); tick();
        tests++; if (halt !== 1'b1 || run_cycles !== 32'd2) begin
            fails++; $display("FAIL halted_frozen: got halt=%0d rc=%0d want 1/2", halt, run_cycles); end
    endtask

    task automatic test_threshold_disable();
        do_reset();
        cfg_slot(2'd1, 32'h0000_0144, 4'd0);
        cfg_slot(2'd2, 32'h0000_0168, 4'd1);
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_0144;
        repeat (5) tick();
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL thresh0_no_halt: got %0d want 0", halt); end
        pc_out = 32'h0000_0168;
        tick();
        pc_load = 1'b0;
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL thresh1_halt: got %0d want 1", halt); end
        tests++; if (halt_slot !== 2'd2) begin fails++; $display("FAIL thresh1_slot: got %0d want 2", halt_slot); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cfg_slot(2'd3, 32'h0000_0154, 4'd1);
        cfg_slot(2'd1, 32'h0000_0154, 4'd1);
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_0154;
        tick();
        pc_load = 1'b0;
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL simul_halt: got %0d want 1", halt); end
        tests++; if (halt_slot !== 2'd1) begin fails++; $display("FAIL simul_slot: got %0d want 1", halt_slot); end
    endtask

    task automatic test_timeout();
        logic seen;
        do_reset();
        tmo_we = 1'b1; tmo_value = 32'd10;
        tick();
        tmo_we = 1'b0;
        do_start();
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (halt === 1'b1) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL tmo_early: got %0d want 0", seen); end
        tick();
        tests++; if (halt !== 1'b1) begin fails++; $display("FAIL tmo_halt: got %0d want 1", halt); end
        tests++; if (halt_cause !== 2'd2) begin fails++; $display("FAIL tmo_cause: got %0d want 2", halt_cause); end
        tests++; if (run_cycles !== 32'd10) begin fails++; $display("FAIL tmo_run_cycles: got %0d want 10", run_cycles); end
    endtask

    task automatic test_timeout_disabled();
        logic seen;
        do_reset();
        do_start();
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (halt === 1'b1) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL tmo0_halt: got %0d want 0", seen); end
        tests++; if (run_cycles !== 32'd1000) begin fails++; $display("FAIL tmo0_run_cycles: got %0d want 1000", run_cycles); end
    endtask

    task automatic test_conflict();
        do_reset();
        mem_read = 1'b1; mem_write = 1'b1;
        repeat (3) tick();
        mem_write = 1'b0;
        tick();
        mem_read = 1'b0; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        tests++; if (rw_conflicts !== 16'd3) begin fails++; $display("FAIL rw_count: got %0d want 3", rw_conflicts); end
    endtask

    task automatic test_pm_error();
        do_reset();
        do_start();
        pm_error = 1'b1;
        tick();
        pm_error = 1'b0;
`ifdef HALT_ON_PM_ERROR_EN
        tests++; if (halt !== 1'b1 || halt_cause !== 2'd3) begin
            fails++; $display("FAIL pm_halt: got halt=%0d cause=%0d want 1/3", halt, halt_cause); end
`else
        tests++; if (halt !== 1'b0 || halt_cause !== 2'd0) begin
            fails++; $display("FAIL pm_ignored: got halt=%0d cause=%0d want 0/0", halt, halt_cause); end
`endif
        // Watch beats pm_error in the same cycle.
        do_reset();
        cfg_slot(2'd0, 32'h0000_0010, 4'd1);
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_0010; pm_error = 1'b1;
        tick();
        pc_load = 1'b0; pm_error = 1'b0;
        tests++; if (halt_cause !== 2'd1) begin fails++; $display("FAIL prio_watch: got %0d want 1", halt_cause); end
        // pm_error versus timeout in the same cycle (reload 1: event in cycle after edge 1).
        do_reset();
        tmo_we = 1'b1; tmo_value = 32'd1;
        do_start();
        tmo_we = 1'b0;
        tick();
        pm_error = 1'b1;
        tick();
        pm_error = 1'b0;
`ifdef HALT_ON_PM_ERROR_EN
        tests++; if (halt_cause !== 2'd3) begin fails++; $display("FAIL prio_pm: got %0d want 3", halt_cause); end
`else
        tests++; if (halt_cause !== 2'd2) begin fails++; $display("FAIL prio_tmo: got %0d want 2", halt_cause); end
`endif
    endtask

    task automatic test_cfg_timing();
        do_reset();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'h0000_0300; cfg_thresh = 4'd1;
        do_start();
        cfg_we = 1'b1; cfg_addr = 32'h0000_0400;
        tick();
        cfg_we = 1'b0;
        pc_load = 1'b1; pc_out = 32'h0000_0400;
        tick();
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL cfg_in_run_ignored: got %0d want 0", halt); end
        pc_out = 32'h0000_0300;
        tick();
        pc_load = 1'b0;
        tests++; if (halt !== 1'b1 || halt_slot !== 2'd0) begin
            fails++; $display("FAIL cfg_with_start: got halt=%0d slot=%0d want 1/0", halt, halt_slot); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        cfg_slot(2'd0, 32'h0000_0200, 4'd2);
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_0200; mem_read = 1'b1; mem_write = 1'b1;
        tick();
        pc_load = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (halt !== 1'b0 || halt_cause !== 2'd0 || run_cycles !== 32'd0 || rw_conflicts !== 16'd0) begin
            fails++; $display("FAIL midrun_reset: got halt=%0d cause=%0d rc=%0d rw=%0d want all 0",
                              halt, halt_cause, run_cycles, rw_conflicts); end
        repeat (3) tick();
        tests++; if (run_cycles !== 32'd0) begin fails++; $display("FAIL midrun_idle: got %0d want 0", run_cycles); end
        do_start();
        pc_load = 1'b1; pc_out = 32'h0000_0200;
        repeat (4) tick();
        pc_load = 1'b0;
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL midrun_old_cfg: got %0d want 0", halt); end
        tests++; if (run_cycles !== 32'd4) begin fails++; $display("FAIL midrun_run_cycles: got %0d want 4", run_cycles); end
    endtask

    initial begin
        test_reset();
        test_watch_single();
        test_threshold_disable();
        test_simultaneous();
        test_timeout();
        test_timeout_disabled();
        test_conflict();
        test_pm_error();
        test_cfg_timing();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
